// File: rtl/random_pkg.sv
// Shared definitions for the random LFSR: maximal-length tap masks for widths 2..32,
// the default seed, the zero-seed substitution and the width legality check.
package random_pkg;

   localparam int unsigned MIN_WIDTH    = 2;
   localparam int unsigned MAX_WIDTH    = 32;
   localparam logic [31:0] DEFAULT_SEED = 32'd1;

   // Tap masks for a left-shifting Fibonacci LFSR; bit i set means state[i] feeds the XOR.
   // Each mask corresponds to a primitive polynomial, so the plain register cycles through
   // all 2^width-1 nonzero states.
   function automatic logic [31:0] tap_mask(input int unsigned width);
      logic [31:0] mask;
      mask = 32'h0;
      case (width)
         2:       mask = 32'h0000_0003;
         3:       mask = 32'h0000_0006;
         4:       mask = 32'h0000_000C;
         5:       mask = 32'h0000_0014;
         6:       mask = 32'h0000_0030;
         7:       mask = 32'h0000_0060;
         8:       mask = 32'h0000_00B8;
         9:       mask = 32'h0000_0110;
         10:      mask = 32'h0000_0240;
         11:      mask = 32'h0000_0500;
         12:      mask = 32'h0000_0829;
         13:      mask = 32'h0000_100D;
         14:      mask = 32'h0000_2015;
         15:      mask = 32'h0000_6000;
         16:      mask = 32'h0000_D008;
         17:      mask = 32'h0001_2000;
         18:      mask = 32'h0002_0400;
         19:      mask = 32'h0004_0023;
         20:      mask = 32'h0009_0000;
         21:      mask = 32'h0014_0000;
         22:      mask = 32'h0030_0000;
         23:      mask = 32'h0042_0000;
         24:      mask = 32'h00E1_0000;
         25:      mask = 32'h0120_0000;
         26:      mask = 32'h0200_0023;
         27:      mask = 32'h0400_0013;
         28:      mask = 32'h0900_0000;
         29:      mask = 32'h1400_0000;
         30:      mask = 32'h2000_0029;
         31:      mask = 32'h4800_0000;
         32:      mask = 32'h8020_0003;
         default: mask = 32'h0;
      endcase
      return mask;
   endfunction

   // Seed truncated to the register width; an all-zero result would lock the plain LFSR,
   // so it is replaced by 1.
   function automatic logic [31:0] effective_seed(input int unsigned width,
                                                  input logic [31:0]  seed);
      logic [31:0] keep;
      logic [31:0] trimmed;
      keep    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      trimmed = seed & keep;
      if (trimmed == 32'd0) begin
         trimmed = 32'd1;
      end
      return trimmed;
   endfunction

   function automatic bit width_ok(input int unsigned width);
      return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
   endfunction

endpackage

// File: rtl/random.sv
// Free-running Fibonacci LFSR pseudo-random source; out is the raw register state.
// Optional build macro RANDOM_DEBRUIJN_EN extends the cycle to include the all-zero state
// (period 2^WIDTH) and drops the zero lock-up guard.
module random
   import random_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter logic [31:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("random: WIDTH must be within 2..32");
   end

   localparam logic [WIDTH-1:0] MASK = WIDTH'(tap_mask(WIDTH));
   localparam logic [WIDTH-1:0] INIT = WIDTH'(effective_seed(WIDTH, SEED));
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] state;

   // Bit shifted into the bottom of the register.
   function automatic logic feedback(input logic [WIDTH-1:0] s);
      logic fb;
      fb = ^(s & MASK);
`ifdef RANDOM_DEBRUIJN_EN
      // Flipping the feedback when all but the top bit are zero splices 0 into the cycle:
      // 100..0 -> 000..0 -> 000..1.
      fb = fb ^ (s[WIDTH-2:0] == '0);
`endif
      return fb;
   endfunction

   // State register: async seed load, otherwise shift in the feedback bit every clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT;
      end else begin
`ifdef RANDOM_DEBRUIJN_EN
         state <= {state[WIDTH-2:0], feedback(state)};
`else
         // All-zero is a dead state for the plain LFSR; kick it back onto the cycle.
         state <= (state == '0) ? ONE : {state[WIDTH-2:0], feedback(state)};
`endif
      end
   end

   assign out = state;

endmodule

// File: tb/tb_random.sv
// Bench for random: 6-bit (SEED 1 and SEED 0) and 8-bit instances checked every cycle
// against a precomputed sequence list, plus directed reset, period and lock-up cases.
module tb_random;

`ifdef RANDOM_DEBRUIJN_EN
   localparam int P6 = 64;
   localparam int P8 = 256;
   localparam int ZERO_HITS = 1;
`else
   localparam int P6 = 63;
   localparam int P8 = 255;
   localparam int ZERO_HITS = 0;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] out6;
   logic [5:0] out0;
   logic [7:0] out8;

   random #(.WIDTH(6), .SEED(32'd1)) dut6 (.clk(clk), .reset(reset), .out(out6));
   random #(.WIDTH(6), .SEED(32'd0)) dut0 (.clk(clk), .reset(reset), .out(out0));
   random #(.WIDTH(8))               dut8 (.clk(clk), .reset(reset), .out(out8));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int steps  = 0;
   bit chk_en  = 1'b0;
   bit chk0_en = 1'b0;
   int unsigned seq6[$];
   int unsigned seq8[$];
   int unsigned lit6[13] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000,
                             6'b100001, 6'b000011, 6'b000110, 6'b001100, 6'b011000,
                             6'b110001, 6'b100010, 6'b000101};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Next value of a w-bit left-shift LFSR: parity of the tapped bits enters at bit 0.
   function automatic int unsigned next_val(input int unsigned s, input int unsigned w,
                                            input int unsigned mask);
      int unsigned par;
      par = int'($countones(s & mask)) % 2;
      return ((s << 1) | par) & ((32'd1 << w) - 1);
   endfunction

   // Clocks taken since the last reset; indexes the expected sequence.
   always @(posedge clk or posedge reset) begin
      if (reset) steps <= 0;
      else       steps <= steps + 1;
   end

   // Per-cycle comparison against the sequence list.
   always @(negedge clk) begin
      if (chk_en) begin
         check("run_w6", {26'd0, out6}, seq6[steps % seq6.size()]);
         check("run_w8", {24'd0, out8}, seq8[steps % seq8.size()]);
         if (chk0_en) check("run_w6_seed0", {26'd0, out0}, seq6[steps % seq6.size()]);
      end
   end

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      #1 reset = 1'b0;
   endtask

   initial begin
      int unsigned s;
      int seen6[64];
      int seen8[256];
      int n6;
      int n8;
      int ret6;
      int ret8;

      // Build the expected cycles.
      s = 1;
      do begin
         seq6.push_back(s);
         s = next_val(s, 6, 32'h30);
      end while (s != 1 && seq6.size() < 300);
      s = 1;
      do begin
         seq8.push_back(s);
         s = next_val(s, 8, 32'hB8);
      end while (s != 1 && seq8.size() < 600);
`ifdef RANDOM_DEBRUIJN_EN
      for (int i = 0; i < seq6.size(); i++) begin
         if (seq6[i] == 32) begin
            seq6.insert(i + 1, 0);
            break;
         end
      end
      for (int i = 0; i < seq8.size(); i++) begin
         if (seq8[i] == 128) begin
            seq8.insert(i + 1, 0);
            break;
         end
      end
`endif

      // Pin the model to hand-derived values.
      for (int i = 0; i < 13; i++) check("model_seq_w6", seq6[i], lit6[i]);
      check("model_period_w6", seq6.size(), P6);
      check("model_period_w8", seq8.size(), P8);

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b1;
      #1;
      check("reset_async_w6", {26'd0, out6}, 32'd1);
      check("reset_async_seed0", {26'd0, out0}, 32'd1);
      check("reset_async_w8", {24'd0, out8}, 32'd1);
      repeat (2) @(posedge clk);
      #1 check("reset_hold_w6", {26'd0, out6}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      chk_en  = 1'b1;
      chk0_en = 1'b1;

      // First 12 values after release.
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         #1 check("seq_w6", {26'd0, out6}, lit6[i]);
      end

      // Period and coverage from a fresh reset.
      pulse_reset();
      for (int i = 0; i < 64; i++) seen6[i] = 0;
      for (int i = 0; i < 256; i++) seen8[i] = 0;
      ret6 = 0;
      ret8 = 0;
      for (int k = 1; k <= P8; k++) begin
         @(negedge clk);
         #1;
         if (k <= P6) begin
            seen6[out6]++;
            if (out6 == 6'd1 && ret6 == 0) ret6 = k;
         end
         seen8[out8]++;
         if (out8 == 8'd1 && ret8 == 0) ret8 = k;
      end
      n6 = 0;
      n8 = 0;
      for (int i = 0; i < 64; i++) if (seen6[i] == 1) n6++;
      for (int i = 0; i < 256; i++) if (seen8[i] == 1) n8++;
      check("cover_w6_distinct", n6, P6);
      check("cover_w6_zero", seen6[0], ZERO_HITS);
      check("return_w6", ret6, P6);
      check("cover_w8_distinct", n8, P8);
      check("cover_w8_zero", seen8[0], ZERO_HITS);
      check("return_w8", ret8, P8);

      // Mid-run reset for part of a cycle.
      pulse_reset();
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("midrst_snap_w6", {26'd0, out6}, 32'd1);
      check("midrst_snap_w8", {24'd0, out8}, 32'd1);
      #1 reset = 1'b0;
      @(negedge clk);
      #1 check("midrst_next_w6", {26'd0, out6}, 32'd2);

      // Forced all-zero state recovers to 1 on the next clock.
      chk0_en = 1'b0;
      @(negedge clk);
      #1 force dut0.state = 6'd0;
      #1 check("force_zero_w6", {26'd0, out0}, 32'd0);
      release dut0.state;
      @(posedge clk);
      #1 check("lockup_recover", {26'd0, out0}, 32'd1);
      pulse_reset();
      chk0_en = 1'b1;
      repeat (8) @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
